// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin owner of one shared SPI byte engine.
// Frames multi-byte transactions with CS setup/hold and a stall watchdog.
module spi_txn_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int LEN_W    = 4,
    parameter int CS_DELAY = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     tx_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       tx_ack,
    output logic [7:0]               rx_data,
    output logic [NUM_REQ-1:0]       rx_valid,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       err,
    output logic [NUM_REQ-1:0]       cs_n,
    output logic                     eng_start,
    output logic [7:0]               eng_data_in,
    input  logic                     eng_busy,
    input  logic                     eng_new_data,
    input  logic [7:0]               eng_data_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(CS_DELAY + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_W    = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CS_DELAY - 1);
    localparam logic [WD_W-1:0]  WD_END   = WD_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        WAIT,
        HOLD,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
    logic [NUM_REQ-1:0] tx_ack_q, tx_ack_d;
    logic [NUM_REQ-1:0] rx_valid_q, rx_valid_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               eng_start_q, eng_start_d;
    logic [7:0]         eng_data_in_q, eng_data_in_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     cand;
    logic [LEN_W-1:0]   pick_len;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] owner_oh;
    logic [7:0]         owner_tx;

    // First asserted request at or above the rr pointer, wrapping once.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (IDX_W + 1)'(k);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!pick_vld && req[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign pick_len = req_len[pick_idx*LEN_W +: LEN_W];
    assign pick_oh  = NUM_REQ'(1) << pick_idx;
    assign owner_oh = NUM_REQ'(1) << owner_q;
    assign owner_tx = tx_data[owner_q*8 +: 8];

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        rem_d         = rem_q;
        cnt_d         = cnt_q;
        wd_d          = wd_q;
        grant_d       = grant_q;
        cs_n_d        = cs_n_q;
        rx_data_d     = rx_data_q;
        eng_data_in_d = eng_data_in_q;
        tx_ack_d      = '0;
        rx_valid_d    = '0;
        done_d        = '0;
        err_d         = '0;
        eng_start_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    rem_d   = (pick_len == '0) ? LEN_ONE : pick_len;
                    grant_d = pick_oh;
                    cs_n_d  = ~pick_oh;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                if (!eng_busy) begin
                    eng_start_d   = 1'b1;
                    eng_data_in_d = owner_tx;
                    tx_ack_d      = owner_oh;
                    wd_d          = '0;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                // A completing byte wins over a watchdog expiring the same cycle.
                if (eng_new_data) begin
                    rx_data_d  = eng_data_out;
                    rx_valid_d = owner_oh;
                    rem_d      = rem_q - 1'b1;
                    if (rem_q == LEN_ONE) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (wd_q == WD_END) begin
                    err_d   = owner_oh;
                    grant_d = '0;
                    cs_n_d  = '1;
                    state_d = GAP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_END) begin
                    cs_n_d  = '1;
                    grant_d = '0;
                    done_d  = owner_oh;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                rr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_q          <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            wd_q          <= '0;
            grant_q       <= '0;
            cs_n_q        <= '1;
            tx_ack_q      <= '0;
            rx_valid_q    <= '0;
            done_q        <= '0;
            err_q         <= '0;
            rx_data_q     <= '0;
            eng_start_q   <= 1'b0;
            eng_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            wd_q          <= wd_d;
            grant_q       <= grant_d;
            cs_n_q        <= cs_n_d;
            tx_ack_q      <= tx_ack_d;
            rx_valid_q    <= rx_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rx_data_q     <= rx_data_d;
            eng_start_q   <= eng_start_d;
            eng_data_in_q <= eng_data_in_d;
        end
    end

    assign grant       = grant_q;
    assign tx_ack      = tx_ack_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cs_n        = cs_n_q;
    assign eng_start   = eng_start_q;
    assign eng_data_in = eng_data_in_q;

    a_cs_matches_grant: assert property (
        @(posedge clk) disable iff (!rst_n) cs_n_q == ~grant_q);
    a_grant_onehot0: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: randomized bench with a behavioural requester,
// byte-engine and round-robin scoreboard.
module tb_spi_txn_arbiter;

    localparam int N   = 4;
    localparam int LW  = 4;
    localparam int CSD = 4;
    localparam int TO  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_len;
    logic [N*8-1:0]  tx_data;
    logic [N-1:0]    grant, tx_ack, rx_valid, done, err, cs_n;
    logic [7:0]      rx_data, eng_data_in, eng_data_out;
    logic            eng_start, eng_busy, eng_new_data;

    spi_txn_arbiter #(
        .NUM_REQ (N),
        .LEN_W   (LW),
        .CS_DELAY(CSD),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_len     (req_len),
        .tx_data     (tx_data),
        .grant       (grant),
        .tx_ack      (tx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .done        (done),
        .err         (err),
        .cs_n        (cs_n),
        .eng_start   (eng_start),
        .eng_data_in (eng_data_in),
        .eng_busy    (eng_busy),
        .eng_new_data(eng_new_data),
        .eng_data_out(eng_data_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0]   data_m [N][16];
    int           len_m [N];
    int           ptr [N];
    logic [N-1:0] req_m;
    bit           active;
    int           own, nbytes, sent, rcv, rr_m, cyc;
    int           t_fall, t_rise, t_start, t_nd;
    logic [7:0]   key, eng_byte;
    bit           rr_hold, stall_req, drop_req, late_pend;
    int           rr_done, n_err;
    int           lat_cd, stall_cd, drop_cd, stall_len;
    logic [N-1:0] glog [$];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            tx_data[i*8 +: 8]    = data_m[i][ptr[i] & 15];
            req_len[i*LW +: LW]  = LW'(len_m[i]);
        end
        req = req_m;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic finish_txn();
        active = 1'b0;
        t_rise = cyc;
        rr_m   = (own + 1) % N;
        if (rr_hold) begin
            rr_done++;
            if (rr_done >= 5) req_m = '0;
        end else begin
            req_m[own] = 1'b0;
        end
        drive();
    endtask

    task automatic step();
        logic [N-1:0] oh, ng, eg, ones;
        int           p;
        @(negedge clk);
        cyc++;
        ones = '1;
        oh   = active ? (N'(1) << own) : '0;
        ng   = ~grant;
        check("cs_vs_grant", cs_n, ng);
        check("grant_onehot0", $onehot0(grant), 1);
        if (eng_start) begin
            check("start_busy", eng_busy, 0);
            check("start_active", active, 1);
            if (active) begin
                if (sent == 0) check("cs_setup", (cyc - t_fall) >= CSD, 1);
                check("tx_byte", eng_data_in, data_m[own][sent & 15]);
                check("tx_ack", tx_ack, oh);
                sent++;
                ptr[own] = sent;
                t_start  = cyc;
                drive();
            end
        end else if (tx_ack != 0) begin
            check("tx_ack_nostart", tx_ack, 0);
        end
        if (rx_valid != 0) begin
            check("rx_active", active, 1);
            if (active) begin
                check("rx_owner", rx_valid, oh);
                check("rx_byte", rx_data, data_m[own][rcv & 15] ^ key);
                rcv++;
            end
        end
        if (done != 0) begin
            check("done_active", active, 1);
            if (active) begin
                check("done_owner", done, oh);
                check("done_bytes", rcv, nbytes);
                check("cs_hold", (cyc - t_nd) >= CSD, 1);
                finish_txn();
            end
        end
        if (err != 0) begin
            check("err_active", active, 1);
            if (active) begin
                check("err_owner", err, oh);
                check("err_latency", cyc - t_start, TO);
                check("err_cs", cs_n, ones);
                check("err_nodone", done, 0);
                n_err++;
                late_pend = 1'b1;
                finish_txn();
            end
        end
        if (!active && grant != 0) begin
            p = pick(req, rr_m);
            check("grant_pick", grant, (p < 0) ? 0 : (1 << p));
            check("cs_gap", (cyc - t_rise) >= 2, 1);
            if (p >= 0) begin
                active = 1'b1;
                own    = p;
                nbytes = (len_m[p] == 0) ? 1 : len_m[p];
                sent   = 0;
                rcv    = 0;
                ptr[p] = 0;
                t_fall = cyc;
                glog.push_back(grant);
                drive();
            end
        end else begin
            eg = active ? (N'(1) << own) : '0;
            check("grant_hold", grant, eg);
        end
        // behavioural byte engine
        eng_new_data = 1'b0;
        if (eng_start) begin
            eng_byte = eng_data_in;
            eng_busy = 1'b1;
            if (drop_req) begin
                drop_req = 1'b0;
                drop_cd  = 3;
            end else begin
                lat_cd = $urandom_range(1, 5);
            end
        end else if (lat_cd > 0) begin
            lat_cd--;
            if (lat_cd == 0) begin
                eng_new_data = 1'b1;
                eng_data_out = eng_byte ^ key;
                t_nd         = cyc;
                if (stall_req) begin
                    stall_req = 1'b0;
                    stall_cd  = stall_len;
                end else begin
                    eng_busy = 1'b0;
                end
            end
        end else if (stall_cd > 0) begin
            stall_cd--;
            if (stall_cd == 0) eng_busy = 1'b0;
        end else if (drop_cd > 0) begin
            drop_cd--;
            if (drop_cd == 0) eng_busy = 1'b0;
        end
        if (late_pend) begin
            late_pend    = 1'b0;
            eng_new_data = 1'b1;
            eng_data_out = 8'h77;
        end
    endtask

    task automatic clear_model();
        req_m = '0;
        active = 1'b0;
        rr_m = 0;
        lat_cd = 0; stall_cd = 0; drop_cd = 0;
        stall_req = 1'b0; drop_req = 1'b0; late_pend = 1'b0;
        eng_busy = 1'b0; eng_new_data = 1'b0; eng_data_out = '0;
        t_rise = -100;
        for (int i = 0; i < N; i++) begin
            len_m[i] = 0;
            ptr[i]   = 0;
            for (int b = 0; b < 16; b++) data_m[i][b] = '0;
        end
        drive();
    endtask

    task automatic do_reset();
        logic [N-1:0] ones;
        ones  = '1;
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_cs_n", cs_n, ones);
        check("rst_grant", grant, 0);
        check("rst_pulses", {tx_ack, rx_valid, done, err}, 0);
        check("rst_eng", {eng_start, eng_data_in, rx_data}, 0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic post(input int i, input int len);
        len_m[i] = len;
        ptr[i]   = 0;
        for (int b = 0; b < 16; b++) data_m[i][b] = 8'($urandom);
        req_m[i] = 1'b1;
        drive();
    endtask

    task automatic run_idle(input int maxc);
        int c;
        c = 0;
        while ((active || req_m != 0 || lat_cd > 0 || stall_cd > 0 ||
                drop_cd > 0) && c < maxc) begin
            step();
            c++;
        end
        check("idle_bound", c < maxc, 1);
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int exp_rr [5];
        cyc = 0; n_err = 0; rr_hold = 1'b0; rr_done = 0; key = 8'h00;
        do_reset();

        // single 3-byte transfer, loopback engine
        post(2, 3);
        data_m[2][0] = 8'hA5;
        data_m[2][1] = 8'h3C;
        data_m[2][2] = 8'hFF;
        drive();
        run_idle(300);
        check("single_owner", glog.size() == 1 && glog[0] == 4'b0100, 1);

        // round robin with all requests held
        do_reset();
        glog.delete();
        rr_hold = 1'b1;
        rr_done = 0;
        key = 8'h5A;
        for (int i = 0; i < N; i++) post(i, 1);
        run_idle(800);
        rr_hold = 1'b0;
        exp_rr = '{0, 1, 2, 3, 0};
        check("rr_count", glog.size(), 5);
        for (int k = 0; k < 5 && k < glog.size(); k++)
            check("rr_order", glog[k], 1 << exp_rr[k]);

        // zero length is one byte
        post(1, 0);
        run_idle(300);

        // engine busy stall in LOAD
        post(3, 3);
        stall_req = 1'b1;
        stall_len = 20;
        run_idle(500);
        check("stall_taken", stall_req, 0);

        // watchdog abort, then the next requester proceeds
        post(0, 2);
        post(1, 1);
        drop_req = 1'b1;
        run_idle(500);
        check("err_count", n_err, 1);

        // randomized traffic
        key = 8'($urandom);
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++)
                if (!req_m[i] && $urandom_range(0, 1) == 1)
                    post(i, $urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0 && !stall_req) begin
                stall_req = 1'b1;
                stall_len = $urandom_range(1, 8);
            end
            repeat ($urandom_range(0, 30)) step();
        end
        run_idle(4000);

        // async reset mid-byte, between clock edges
        post(3, 3);
        c = 0;
        while (!(active && sent > 0) && c < 200) begin
            step();
            c++;
        end
        check("ar_reach", c < 200, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_cs_n", cs_n, 4'b1111);
        check("ar_grant", grant, 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        glog.delete();
        post(1, 1);
        post(2, 1);
        post(3, 1);
        run_idle(400);
        check("ar_rr_first", glog.size() > 0 && glog[0] == 4'b0010, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
